// File: rtl/rom_fetch_arbiter.sv
// Round-robin arbiter sharing the single-ported instruction ROM between the
// instruction-fetch (IF) and data-memory (DM) read ports, with one-cycle registered responses.
module rom_fetch_arbiter #(
  parameter logic [31:0] ROM_LIMIT = 32'h0000_1000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             if_req,
  input  logic [31:0]      if_addr,
  input  logic             if_flush,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [31:0]      if_rdata,
  output logic             if_err,

  input  logic             dm_req,
  input  logic [31:0]      dm_addr,
  output logic             dm_gnt,
  output logic             dm_rvalid,
  output logic [31:0]      dm_rdata,
  output logic             dm_err,

  output logic             rom_en,
  output logic [30:0]      rom_addr,
  input  logic [31:0]      rom_data,

  output logic [CNT_W-1:0] conflict_cnt
);

  // last_q: 0 = IF granted last, 1 = DM granted last
  logic             last_q, last_d;
  logic             if_pend_q, dm_pend_q;
  logic [31:0]      if_rdata_q, dm_rdata_q;
  logic             if_err_q, dm_err_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0] sel_addr;
  logic        any_gnt;
  logic        acc_err;
  logic [31:0] resp_data;
  logic        both_req;

  assign both_req = if_req & dm_req;

  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    last_d    = last_q;
    sel_addr  = 32'h0;
    acc_err   = 1'b0;
    rom_en    = 1'b0;
    rom_addr  = 31'h0;
    resp_data = 32'h0;

    if (rst_n) begin
      if (both_req) begin
        if_gnt = last_q;
        dm_gnt = ~last_q;
      end else begin
        if_gnt = if_req;
        dm_gnt = dm_req;
      end
    end

    if (if_gnt) begin
      sel_addr = if_addr;
      last_d   = 1'b0;
    end else if (dm_gnt) begin
      sel_addr = dm_addr;
      last_d   = 1'b1;
    end

    any_gnt = if_gnt | dm_gnt;
    acc_err = any_gnt & ((sel_addr[1:0] != 2'b00) | (sel_addr >= ROM_LIMIT));

    // Erroneous accesses are answered but never reach the ROM.
    if (any_gnt && !acc_err) begin
      rom_en    = 1'b1;
      rom_addr  = sel_addr[30:0];
      resp_data = rom_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= 1'b1;
      if_pend_q  <= 1'b0;
      dm_pend_q  <= 1'b0;
      if_rdata_q <= 32'h0;
      dm_rdata_q <= 32'h0;
      if_err_q   <= 1'b0;
      dm_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      last_q    <= last_d;
      if_pend_q <= if_gnt;
      dm_pend_q <= dm_gnt;
      if (if_gnt) begin
        if_rdata_q <= resp_data;
        if_err_q   <= acc_err;
      end
      if (dm_gnt) begin
        dm_rdata_q <= resp_data;
        dm_err_q   <= acc_err;
      end
      if (both_req && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Flush only masks the strobe; data and error still reflect the dropped response.
  assign if_rvalid    = if_pend_q & ~if_flush;
  assign if_rdata     = if_rdata_q;
  assign if_err       = if_err_q;
  assign dm_rvalid    = dm_pend_q;
  assign dm_rdata     = dm_rdata_q;
  assign dm_err       = dm_err_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Self-checking bench for rom_fetch_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the sharing rules.
module tb_rom_fetch_arbiter;

  localparam int unsigned CNT_W     = 4;
  localparam logic [31:0] ROM_LIMIT = 32'h0000_1000;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             if_req, if_flush, dm_req;
  logic [31:0]      if_addr, dm_addr;
  logic             if_gnt, if_rvalid, if_err;
  logic             dm_gnt, dm_rvalid, dm_err;
  logic [31:0]      if_rdata, dm_rdata;
  logic             rom_en;
  logic [30:0]      rom_addr;
  logic [31:0]      rom_data;
  logic [CNT_W-1:0] conflict_cnt;

  logic [31:0] mem [1024];

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state: which port went last, what each port is owed next cycle.
  bit          m_dm_went_last;
  bit          m_if_owed, m_dm_owed;
  logic [31:0] m_if_data, m_dm_data;
  bit          m_if_err, m_dm_err;
  int          m_cnt;

  always #5 clk = ~clk;

  assign rom_data = mem[rom_addr[11:2]];

  rom_fetch_arbiter #(
    .ROM_LIMIT (ROM_LIMIT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_flush     (if_flush),
    .if_gnt       (if_gnt),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .if_err       (if_err),
    .dm_req       (dm_req),
    .dm_addr      (dm_addr),
    .dm_gnt       (dm_gnt),
    .dm_rvalid    (dm_rvalid),
    .dm_rdata     (dm_rdata),
    .dm_err       (dm_err),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .conflict_cnt (conflict_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dm_went_last = 1'b1;
    m_if_owed = 1'b0;
    m_dm_owed = 1'b0;
    m_if_data = 32'h0;
    m_dm_data = 32'h0;
    m_if_err  = 1'b0;
    m_dm_err  = 1'b0;
    m_cnt     = 0;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_if_gnt"}, {31'h0, if_gnt}, 32'h0);
    check_val({tag, "_dm_gnt"}, {31'h0, dm_gnt}, 32'h0);
    check_val({tag, "_rom_en"}, {31'h0, rom_en}, 32'h0);
    check_val({tag, "_rom_addr"}, {1'b0, rom_addr}, 32'h0);
    check_val({tag, "_if_rvalid"}, {31'h0, if_rvalid}, 32'h0);
    check_val({tag, "_dm_rvalid"}, {31'h0, dm_rvalid}, 32'h0);
    check_val({tag, "_if_rdata"}, if_rdata, 32'h0);
    check_val({tag, "_dm_rdata"}, dm_rdata, 32'h0);
    check_val({tag, "_if_err"}, {31'h0, if_err}, 32'h0);
    check_val({tag, "_dm_err"}, {31'h0, dm_err}, 32'h0);
    check_val({tag, "_cnt"}, {{(32-CNT_W){1'b0}}, conflict_cnt}, 32'h0);
  endtask

  // One clock cycle: drive inputs after the falling edge, check just after, then advance model.
  task automatic cyc(input bit ir, input logic [31:0] ia, input bit fl,
                     input bit dr, input logic [31:0] da);
    bit          g_if, g_dm, bad;
    logic [31:0] a, d;
    @(negedge clk);
    if_req = ir; if_addr = ia; if_flush = fl;
    dm_req = dr; dm_addr = da;
    #1;
    g_if = ir && (!dr || m_dm_went_last);
    g_dm = dr && !g_if;
    a    = g_if ? ia : da;
    bad  = (a % 4 != 0) || (a >= ROM_LIMIT);
    d    = bad ? 32'h0 : mem[a / 4];
    check_val("if_gnt", {31'h0, if_gnt}, {31'h0, g_if});
    check_val("dm_gnt", {31'h0, dm_gnt}, {31'h0, g_dm});
    check_val("rom_en", {31'h0, rom_en}, {31'h0, (g_if || g_dm) && !bad});
    check_val("rom_addr", {1'b0, rom_addr}, ((g_if || g_dm) && !bad) ? a : 32'h0);
    check_val("if_rvalid", {31'h0, if_rvalid}, {31'h0, m_if_owed && !fl});
    check_val("dm_rvalid", {31'h0, dm_rvalid}, {31'h0, m_dm_owed});
    check_val("if_rdata", if_rdata, m_if_data);
    check_val("if_err", {31'h0, if_err}, {31'h0, m_if_err});
    check_val("dm_rdata", dm_rdata, m_dm_data);
    check_val("dm_err", {31'h0, dm_err}, {31'h0, m_dm_err});
    check_val("conflict_cnt", {{(32-CNT_W){1'b0}}, conflict_cnt}, m_cnt);
    m_if_owed = g_if;
    m_dm_owed = g_dm;
    if (g_if) begin m_if_data = d; m_if_err = bad; m_dm_went_last = 1'b0; end
    if (g_dm) begin m_dm_data = d; m_dm_err = bad; m_dm_went_last = 1'b1; end
    if (ir && dr && m_cnt < CNT_MAX) m_cnt++;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      6:       return {$urandom_range(0, 1023), 2'b00} | $urandom_range(1, 3);
      7:       return 32'h0000_0FFC;
      8:       return $urandom_range(32'h1000, 32'hFFFF_FFFF);
      9:       return 32'h0000_1000;
      default: return {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0]    = 32'h8000_0337;
    mem[1]    = 32'h0003_03E7;
    mem[1023] = 32'h0;

    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_addr = '0;
    model_reset();
    #1;
    check_quiet("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Conflict round-robin straight out of reset.
    for (int i = 0; i < 4; i++) cyc(1, 32'h0, 0, 1, 32'h4);
    cyc(0, 32'h0, 0, 0, 32'h0);
    check_val("rr_cnt4", {{(32-CNT_W){1'b0}}, conflict_cnt}, 32'd4);

    // IF-only fetches.
    cyc(1, 32'h0, 0, 0, 32'h0);
    cyc(1, 32'h4, 0, 0, 32'h0);
    check_val("if_word0", if_rdata, 32'h8000_0337);
    cyc(0, 32'h0, 0, 0, 32'h0);
    check_val("if_word1", if_rdata, 32'h0003_03E7);

    // DM errors and the last legal word.
    cyc(0, 32'h0, 0, 1, 32'h2);
    cyc(0, 32'h0, 0, 1, 32'h1000);
    check_val("dm_misalign_err", {31'h0, dm_err}, 32'h1);
    cyc(0, 32'h0, 0, 1, 32'h0FFC);
    check_val("dm_range_err", {31'h0, dm_err}, 32'h1);
    cyc(0, 32'h0, 0, 0, 32'h0);
    check_val("dm_last_word_err", {31'h0, dm_err}, 32'h0);

    // Flush: dropped response, then a flush alongside a new grant.
    cyc(1, 32'h4, 0, 0, 32'h0);
    cyc(0, 32'h0, 1, 0, 32'h0);
    cyc(1, 32'h4, 0, 0, 32'h0);
    cyc(1, 32'h0, 1, 0, 32'h0);
    cyc(0, 32'h0, 0, 0, 32'h0);
    check_val("flush_then_valid", {31'h0, if_rvalid}, 32'h1);

    // Saturation of the conflict counter.
    for (int i = 0; i < 20; i++) cyc(1, rand_addr(), 0, 1, rand_addr());
    cyc(0, 32'h0, 0, 0, 32'h0);
    check_val("cnt_sat", {{(32-CNT_W){1'b0}}, conflict_cnt}, CNT_MAX);

    // Reset while an IF access is in flight.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0; dm_req = 1'b0;
    #1;
    check_val("pre_rst_gnt", {31'h0, if_gnt}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_quiet("mid_rst");
    @(posedge clk);
    @(negedge clk);
    if_req = 1'b0;
    rst_n  = 1'b1;
    cyc(0, 32'h0, 0, 0, 32'h0);
    cyc(1, 32'h8, 0, 1, 32'hC);
    check_val("post_rst_if_wins", {31'h0, if_gnt}, 32'h1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(bit'($urandom_range(0, 3) != 0), rand_addr(), bit'($urandom_range(0, 4) == 0),
          bit'($urandom_range(0, 2) != 0), rand_addr());
    end
    cyc(0, 32'h0, 0, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
